// File: rtl/iob_vexriscv_bus_arb.sv
// iob_vexriscv_bus_arb: two-master (ibus m0, dbus m1) to one-slave IOb arbiter
// with zero-latency request forwarding and a single outstanding read.
module iob_vexriscv_bus_arb #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int PRIO_MODE = 0
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  cke_i,
    input  logic [1:0]            m_avalid_i,
    input  logic [2*ADDR_W-1:0]   m_addr_i,
    input  logic [2*DATA_W-1:0]   m_wdata_i,
    input  logic [2*DATA_W/8-1:0] m_wstrb_i,
    output logic [1:0]            m_ready_o,
    output logic [1:0]            m_rvalid_o,
    output logic [DATA_W-1:0]     m_rdata_o,
    output logic                  s_avalid_o,
    output logic [ADDR_W-1:0]     s_addr_o,
    output logic [DATA_W-1:0]     s_wdata_o,
    output logic [DATA_W/8-1:0]   s_wstrb_o,
    input  logic                  s_ready_i,
    input  logic                  s_rvalid_i,
    input  logic [DATA_W-1:0]     s_rdata_i,
    output logic                  busy_o
);
    localparam int STRB_W = DATA_W/8;

    typedef enum logic [1:0] {IDLE, HOLD, RD_WAIT} state_t;

    state_t r_state;
    logic   r_owner, r_last, r_grant, r_en;
    logic   w_win, w_sel, w_sv, w_acc, w_rd, w_rv;

    always_comb begin
        w_win = (&m_avalid_i) ? ((PRIO_MODE != 0) ? 1'b1 : ~r_last) : m_avalid_i[1];
        w_sel = (r_state == HOLD) ? r_grant : w_win;
        // once parked in HOLD the request is committed, no re-arbitration
        w_sv  = r_en & ((r_state == HOLD) | ((r_state == IDLE) & (|m_avalid_i)));
        w_acc = w_sv & s_ready_i;
        w_rd  = ~|s_wstrb_o;
        w_rv  = r_en & (r_state == RD_WAIT) & s_rvalid_i;
    end

    assign s_avalid_o = w_sv;
    assign s_addr_o   = !w_sv ? '0 : w_sel ? m_addr_i[2*ADDR_W-1:ADDR_W] : m_addr_i[ADDR_W-1:0];
    assign s_wdata_o  = !w_sv ? '0 : w_sel ? m_wdata_i[2*DATA_W-1:DATA_W] : m_wdata_i[DATA_W-1:0];
    assign s_wstrb_o  = !w_sv ? '0 : w_sel ? m_wstrb_i[2*STRB_W-1:STRB_W] : m_wstrb_i[STRB_W-1:0];
    assign m_ready_o  = w_acc ? {w_sel, ~w_sel} : 2'b00;
    assign m_rvalid_o = w_rv ? {r_owner, ~r_owner} : 2'b00;
    assign m_rdata_o  = s_rdata_i;
    assign busy_o     = r_en & (r_state != IDLE);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_grant <= 1'b0;
            r_en    <= 1'b0;
        end else if (cke_i) begin
            r_en <= 1'b1;
            if (w_acc) begin
                r_last  <= w_sel;
                r_owner <= w_rd ? w_sel : r_owner;
                r_state <= w_rd ? RD_WAIT : IDLE;
            end else if (w_sv) begin
                r_grant <= w_sel;
                r_state <= HOLD;
            end else if (w_rv) begin
                r_state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_iob_vexriscv_bus_arb.sv
// tb_iob_vexriscv_bus_arb: round-robin (u0) and fixed-priority (u1) arbiters driven
// side by side, checked every cycle against a master-level model plus literal vectors.
module tb_iob_vexriscv_bus_arb;
    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        cke;
    logic [1:0]  m_av;
    logic [31:0] a0, a1, d0, d1;
    logic [3:0]  ws0, ws1;
    logic        s_rdy, s_rv;
    logic [31:0] s_rd;

    logic [1:0]  rdy [2];
    logic [1:0]  rv [2];
    logic [31:0] rdat [2];
    logic [31:0] sad [2];
    logic [31:0] swd [2];
    logic [3:0]  sws [2];
    logic        sav [2];
    logic        bsy [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    iob_vexriscv_bus_arb #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(0)) u0 (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .m_avalid_i(m_av),
        .m_addr_i({a1, a0}), .m_wdata_i({d1, d0}), .m_wstrb_i({ws1, ws0}),
        .m_ready_o(rdy[0]), .m_rvalid_o(rv[0]), .m_rdata_o(rdat[0]),
        .s_avalid_o(sav[0]), .s_addr_o(sad[0]), .s_wdata_o(swd[0]), .s_wstrb_o(sws[0]),
        .s_ready_i(s_rdy), .s_rvalid_i(s_rv), .s_rdata_i(s_rd), .busy_o(bsy[0]));

    iob_vexriscv_bus_arb #(.ADDR_W(32), .DATA_W(32), .PRIO_MODE(1)) u1 (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .m_avalid_i(m_av),
        .m_addr_i({a1, a0}), .m_wdata_i({d1, d0}), .m_wstrb_i({ws1, ws0}),
        .m_ready_o(rdy[1]), .m_rvalid_o(rv[1]), .m_rdata_o(rdat[1]),
        .s_avalid_o(sav[1]), .s_addr_o(sad[1]), .s_wdata_o(swd[1]), .s_wstrb_o(sws[1]),
        .s_ready_i(s_rdy), .s_rvalid_i(s_rv), .s_rdata_i(s_rd), .busy_o(bsy[1]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state per instance: master awaiting read data (-1 none), master parked
    // waiting for slave ready (-1 none), last accepted master, enable seen.
    int pend [2];
    int hold [2];
    int npend [2];
    int nhold [2];
    bit last [2];
    bit nlast [2];
    bit en [2];
    int who;
    logic [1:0]  e_rdy, e_rv;
    logic        e_sav, e_bsy;
    logic [31:0] e_ad, e_wd;
    logic [3:0]  e_ws;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            e_rdy = 2'b00; e_rv = 2'b00; e_sav = 1'b0; e_bsy = 1'b0;
            e_ad = '0; e_wd = '0; e_ws = '0; who = -1;
            npend[i] = pend[i]; nhold[i] = hold[i]; nlast[i] = last[i];
            if (arst_n && en[i]) begin
                e_bsy = (pend[i] >= 0) || (hold[i] >= 0);
                if (pend[i] >= 0) begin
                    if (s_rv) begin
                        e_rv = (pend[i] == 1) ? 2'b10 : 2'b01;
                        npend[i] = -1;
                    end
                end else begin
                    if (hold[i] >= 0) who = hold[i];
                    else if (m_av == 2'b11) who = (i == 1) ? 1 : (last[i] ? 0 : 1);
                    else if (m_av[0]) who = 0;
                    else if (m_av[1]) who = 1;
                    if (who >= 0) begin
                        e_sav = 1'b1;
                        e_ad = (who == 1) ? a1 : a0;
                        e_wd = (who == 1) ? d1 : d0;
                        e_ws = (who == 1) ? ws1 : ws0;
                        if (s_rdy) begin
                            e_rdy = (who == 1) ? 2'b10 : 2'b01;
                            nlast[i] = (who == 1);
                            nhold[i] = -1;
                            npend[i] = (e_ws == 4'h0) ? who : -1;
                        end else begin
                            nhold[i] = who;
                        end
                    end
                end
            end
            chk($sformatf("u%0d.s_avalid", i), 64'(sav[i]), 64'(e_sav));
            chk($sformatf("u%0d.s_addr", i), 64'(sad[i]), 64'(e_ad));
            chk($sformatf("u%0d.s_wdata", i), 64'(swd[i]), 64'(e_wd));
            chk($sformatf("u%0d.s_wstrb", i), 64'(sws[i]), 64'(e_ws));
            chk($sformatf("u%0d.m_ready", i), 64'(rdy[i]), 64'(e_rdy));
            chk($sformatf("u%0d.m_rvalid", i), 64'(rv[i]), 64'(e_rv));
            chk($sformatf("u%0d.m_rdata", i), 64'(rdat[i]), 64'(s_rd));
            chk($sformatf("u%0d.busy", i), 64'(bsy[i]), 64'(e_bsy));
        end
    end

    always @(posedge clk or negedge arst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!arst_n) begin
                pend[i] <= -1; hold[i] <= -1; last[i] <= 1'b1; en[i] <= 1'b0;
            end else if (cke) begin
                en[i] <= 1'b1; pend[i] <= npend[i]; hold[i] <= nhold[i]; last[i] <= nlast[i];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        s_rd = '0;
        @(negedge clk);
        chk("rst.busy", 64'(bsy[0]), 64'd0);
        chk("rst.m_ready", 64'(rdy[0]), 64'd0);
        chk("rst.s_avalid", 64'(sav[1]), 64'd0);
        tick();
        tick();
        arst_n = 1'b1;
        m_av = 2'b01;
        s_rdy = 1'b1;
        @(negedge clk);
        chk("pre_en.s_avalid", 64'(sav[0]), 64'd0);
        chk("pre_en.m_ready", 64'(rdy[0]), 64'd0);
        tick();
        m_av = 2'b00;
        s_rdy = 1'b0;
    endtask

    initial begin
        cke = 1'b1; m_av = '0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        ws0 = '0; ws1 = '0; s_rdy = 1'b0; s_rv = 1'b0; s_rd = '0;
        do_reset();

        // single m0 read, data back two cycles later
        a0 = 32'h100; ws0 = 4'h0; m_av = 2'b01; s_rdy = 1'b1;
        @(negedge clk);
        chk("t1.ready", 64'(rdy[0]), 64'h1);
        chk("t1.addr", 64'(sad[0]), 64'h100);
        tick();
        m_av = 2'b00; s_rdy = 1'b0;
        @(negedge clk);
        chk("t1.busy", 64'(bsy[0]), 64'd1);
        tick();
        s_rv = 1'b1; s_rd = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1.rvalid", 64'(rv[0]), 64'h1);
        chk("t1.rvalid_prio", 64'(rv[1]), 64'h1);
        chk("t1.rdata", 64'(rdat[0]), 64'hDEADBEEF);
        tick();
        s_rv = 1'b0; s_rd = '0;

        // both masters read continuously: u0 alternates, u1 always m1
        do_reset();
        a0 = 32'h200; a1 = 32'h300; ws0 = 4'h0; ws1 = 4'h0; m_av = 2'b11; s_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s_rv = k[0];
            s_rd = k;
            @(negedge clk);
            if (k % 2 == 0) begin
                chk("t2.addr", 64'(sad[0]), (k % 4 == 0) ? 64'h200 : 64'h300);
                chk("t2.ready", 64'(rdy[0]), (k % 4 == 0) ? 64'h1 : 64'h2);
                chk("t3.addr", 64'(sad[1]), 64'h300);
                chk("t3.m0_ready", 64'(rdy[1][0]), 64'd0);
            end
            tick();
        end
        m_av = 2'b00; s_rv = 1'b0; s_rd = '0;

        // m0 write stalled three cycles; m1 waits behind it
        a0 = 32'h500; ws0 = 4'hF; d0 = 32'hAAAA5555; a1 = 32'h600; ws1 = 4'h0;
        m_av = 2'b01;
        for (int k = 0; k < 4; k++) begin
            if (k >= 1) m_av = 2'b11;
            s_rdy = (k == 3);
            @(negedge clk);
            chk("t4.addr_rr", 64'(sad[0]), 64'h500);
            chk("t4.addr_prio", 64'(sad[1]), 64'h500);
            chk("t4.m1_ready", 64'(rdy[0][1]), 64'd0);
            tick();
        end
        m_av = 2'b10; s_rdy = 1'b1;
        @(negedge clk);
        chk("t4.m1_acc", 64'(rdy[0]), 64'h2);
        chk("t4.m1_addr", 64'(sad[1]), 64'h600);
        tick();
        m_av = 2'b00; s_rv = 1'b1; s_rd = 32'h600D;
        @(negedge clk);
        chk("t4.m1_rvalid", 64'(rv[0]), 64'h2);
        tick();
        s_rv = 1'b0;

        // m1 write then immediate m0 read
        a1 = 32'h40; ws1 = 4'hF; d1 = 32'hCAFE; m_av = 2'b10; s_rdy = 1'b1;
        @(negedge clk);
        chk("t5.wr_ready", 64'(rdy[0]), 64'h2);
        tick();
        a0 = 32'h100; ws0 = 4'h0; m_av = 2'b01;
        @(negedge clk);
        chk("t5.busy", 64'(bsy[0]), 64'd0);
        chk("t5.m0_ready", 64'(rdy[0]), 64'h1);
        tick();
        m_av = 2'b00; s_rv = 1'b1; s_rd = 32'h12345678;
        @(negedge clk);
        chk("t5.rvalid", 64'(rv[0]), 64'h1);
        tick();
        s_rv = 1'b0;

        // reset while waiting for read data; late response is dropped
        a0 = 32'h100; ws0 = 4'h0; m_av = 2'b01; s_rdy = 1'b1;
        tick();
        m_av = 2'b00; arst_n = 1'b0; s_rd = '0;
        @(negedge clk);
        chk("t6.busy", 64'(bsy[0]), 64'd0);
        chk("t6.s_avalid", 64'(sav[0]), 64'd0);
        tick();
        tick();
        arst_n = 1'b1;
        tick();
        tick();
        s_rv = 1'b1; s_rd = 32'hBAD0BAD0;
        @(negedge clk);
        chk("t6.late_rv_rr", 64'(rv[0]), 64'h0);
        chk("t6.late_rv_prio", 64'(rv[1]), 64'h0);
        chk("t6.rdata", 64'(rdat[0]), 64'hBAD0BAD0);
        tick();
        s_rv = 1'b0;

        // clock enable low freezes the FSM while outputs follow it
        a0 = 32'h700; m_av = 2'b01; s_rdy = 1'b1;
        tick();
        m_av = 2'b00; cke = 1'b0; s_rv = 1'b1; s_rd = 32'h77;
        @(negedge clk);
        chk("t7.comb_rv", 64'(rv[0]), 64'h1);
        tick();
        cke = 1'b1;
        @(negedge clk);
        chk("t7.frozen_busy", 64'(bsy[0]), 64'd1);
        chk("t7.frozen_rv", 64'(rv[0]), 64'h1);
        tick();
        s_rv = 1'b0;
        @(negedge clk);
        chk("t7.idle", 64'(bsy[0]), 64'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
